// File: rtl/sized_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sized_deser_pkg
// Description : Shared types and constants for the sized_deser deserializer.
//               - state_t     : FILL / HOLD state encoding
//               - clog2_min1  : max(1, $clog2(n+1)), used for counter widths
//               - MIN_WIDTH / MAX_WIDTH : legal word-width limits
// Revision    : 1.0 - initial release
// ============================================================================
package sized_deser_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 1024;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Width needed to count 0..n inclusive, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n + 1);
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sized_deser_shreg.sv
`default_nettype none
// ============================================================================
// Module      : sized_deser_shreg
// Description : WIDTH-bit collection register for sized_deser. Each written
//               bit lands at the position selected by the fill count and the
//               bit order; load_first restarts a word with din as its first
//               bit. word_next is the register contents including din, so a
//               word completed this cycle can be captured downstream.
// Ports       : clk, rst_n (async, active low), clr (sync clear),
//               wr_en (write din), load_first (restart word with din),
//               din, fill (bits already collected), word_next (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sized_deser_shreg
    import sized_deser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1,
    parameter int CW        = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             load_first,
    input  logic             din,
    input  logic [CW-1:0]    fill,
    output logic [WIDTH-1:0] word_next
);

    generate
        if (WIDTH == 1) begin : g_single
            // A one-bit word is complete as soon as its bit arrives, so there
            // is nothing to accumulate; the downstream word register holds it.
            assign word_next = din;
        end else begin : g_multi
            localparam int          c_iw  = CW + 1;
            localparam logic [CW:0] c_top = c_iw'(WIDTH - 1);

            logic [WIDTH-1:0] r_q;
            logic [CW:0]      w_idx;
            logic [WIDTH-1:0] w_next;

            // Index is one bit wider than fill so WIDTH-1-fill never wraps.
            always_comb begin
                w_next = load_first ? '0 : r_q;
                if (load_first)
                    w_idx = (LSB_FIRST != 0) ? '0 : c_top;
                else
                    w_idx = (LSB_FIRST != 0) ? {1'b0, fill} : (c_top - {1'b0, fill});
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_idx == c_iw'(i))
                        w_next[i] = din;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_q <= '0;
                else if (clr)
                    r_q <= '0;
                else if (wr_en)
                    r_q <= w_next;
            end

            assign word_next = w_next;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sized_deser.sv
`default_nettype none
// ============================================================================
// Module      : sized_deser
// Description : Serial-to-parallel deserializer. Collects single bits
//               (valid/ready) into a WIDTH-bit word (valid/ready).
//               Optional macro SIZED_DESER_PARITY_EN adds out_parity, the
//               XOR of out_data, registered alongside out_data.
// Ports       : clk, rst_n (async, active low), flush (sync discard),
//               in_valid/in_bit/in_ready  : serial input handshake
//               out_valid/out_ready/out_data : word output handshake
//               out_parity (optional), fill_count (bits collected)
// Revision    : 1.0 - initial release
// ============================================================================
module sized_deser
    import sized_deser_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int LSB_FIRST = 1,
    localparam int CW        = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef SIZED_DESER_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CW-1:0]    fill_count
);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("sized_deser: WIDTH outside legal range");
        end
    endgenerate

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_full = CW'(WIDTH);

    state_t           r_state;
    logic             w_in_hold;
    logic             w_accept;
    logic             w_deliver;
    logic             w_last;
    logic             w_load_word;
    logic [WIDTH-1:0] w_word_next;

    assign w_in_hold = (r_state == ST_HOLD);
    // While holding, a new bit can only enter if the held word leaves now.
    assign in_ready  = w_in_hold ? out_ready : 1'b1;
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = out_valid & out_ready;
    assign w_last    = (fill_count == c_last);
    // A word completes on the WIDTH-th bit in FILL, or, for a one-bit word,
    // on any accept in HOLD (which implies the held word is delivered).
    assign w_load_word = ~flush & w_accept & (w_in_hold ? (WIDTH == 1) : w_last);

    sized_deser_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .CW        (CW)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (flush | w_load_word),
        .wr_en      (w_accept & ~flush),
        .load_first (w_in_hold),
        .din        (in_bit),
        .fill       (fill_count),
        .word_next  (w_word_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (flush) begin
            r_state    <= ST_FILL;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (w_load_word)
                out_data <= w_word_next;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state    <= ST_HOLD;
                            fill_count <= c_full;
                            out_valid  <= 1'b1;
                        end else begin
                            fill_count <= fill_count + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // One-bit words chain back-to-back and stay in HOLD.
                    if (w_deliver && !(w_accept && WIDTH == 1)) begin
                        r_state    <= ST_FILL;
                        out_valid  <= 1'b0;
                        fill_count <= w_accept ? CW'(1) : '0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

`ifdef SIZED_DESER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_parity <= 1'b0;
        else if (flush)
            out_parity <= 1'b0;
        else if (w_load_word)
            out_parity <= ^w_word_next;
    end
`endif

endmodule
`default_nettype wire

// File: doc/sized_deser.md
Name: sized_deser

Overview:
- Parametrised serial-to-parallel deserializer that collects single bits into a WIDTH-bit word. It replaces fixed, hand-sized sub-blocks whose derived ranges break at small parameter values.
- All derived ranges are clamped so no declared range ever has a negative or reversed index, for any legal WIDTH, including WIDTH=1.
- It sits between bit-serial producers and word-oriented consumers, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 4, output word width in bits; legal range 1..1024; WIDTH<1 is an elaboration error via a generate-time check.
- LSB_FIRST, 1, 1: first accepted bit lands in out_data[0]; 0: first accepted bit lands in out_data[WIDTH-1].
- CW (localparam), max(1, $clog2(WIDTH+1)), width of fill_count; never 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of partial and held word
- in_valid  input  1  in_bit is valid this cycle
- in_bit  input  1  serial data bit
- in_ready  output  1  block accepts in_bit this cycle
- out_valid  output  1  out_data holds a complete word
- out_ready  input  1  consumer takes the word this cycle
- out_data  output  WIDTH  assembled word
- fill_count  output  CW  bits collected toward the current word (0..WIDTH-1 in FILL; WIDTH in HOLD)

Behaviour:
- Reset (rst_n low, asynchronous): state=FILL, shift register=0, fill_count=0, out_valid=0, out_data=0, in_ready=1. Release is synchronous to clk.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- State FILL: in_ready=1, out_valid=0.
  - On accept, shift in_bit into the register per LSB_FIRST and increment fill_count.
  - If fill_count==WIDTH-1 on accept, go to HOLD next cycle with out_valid=1 and fill_count=WIDTH.
  - Latency: the word is visible the cycle after its WIDTH-th bit is accepted.
- State HOLD: out_valid=1, out_data stable, in_ready=out_ready (combinational pass-through).
  - Deliver without accept: go to FILL, fill_count=0.
  - Deliver with accept, WIDTH>1: go to FILL, fill_count=1, register holds the new bit as first bit.
  - Deliver with accept, WIDTH==1: stay in HOLD; the new word equals in_bit.
  - No deliver: hold everything; an input with in_valid=1 stays stalled (in_ready=0).
- flush: has priority over accept and deliver. Next state is FILL, fill_count=0, register=0, out_valid=0. A word held at flush is lost even if out_ready=1 that cycle, and no deliver is counted.
- Unused register bits are never read, so a partial word is never exposed on out_data.
- Width rules:
  - The shift index is computed in CW+1 bits.
  - No range of the form [WIDTH-2:0] is declared; WIDTH=1 uses a 1-bit register and omits the shift path by generate.
- in_bit X while in_valid=0 must not propagate into the register.

Optional Feature:
- Macro SIZED_DESER_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = XOR of out_data, valid whenever out_valid=1. It is registered together with out_data, with no added latency, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sized_deser_pkg holds:
  - the state enum type (FILL, HOLD);
  - a constant function clog2_min1(n) returning max(1, $clog2(n+1));
  - the WIDTH legality limits (MIN_WIDTH=1, MAX_WIDTH=1024).
- One natural sub-module, sized_deser_shreg: WIDTH-bit shift register with load-first-bit and clear controls, parameterised on WIDTH and LSB_FIRST, with a generate branch for WIDTH=1.
- The FSM and handshakes stay in the top module.

Test Plan:
- WIDTH=4, LSB_FIRST=1: bits 1,0,1,1 accepted on consecutive cycles -> next cycle out_valid=1, out_data=4'b1101, fill_count=4, in_ready tracks out_ready.
- WIDTH=4, LSB_FIRST=0, same bits -> out_data=4'b1011.
- WIDTH=1: hold out_ready=1, in_valid=1, stream 1,0,1 -> out_data is 1,0,1 on consecutive cycles after the first; out_valid stays high; no bubbles.
- WIDTH=8: hold word 8'hA5 with out_ready=0 for 5 cycles while in_valid=1 -> out_data stable, in_ready=0, no bit lost; then out_ready=1 with in_bit=1 -> FILL, fill_count=1.
- WIDTH=3: flush asserted after 2 bits, and again while a word is held with out_ready=1 -> fill_count=0, out_valid=0 next cycle, no delivery.
- Reset mid-word (rst_n low asynchronously during FILL, fill_count=2) -> outputs immediately 0, in_ready=1. With SIZED_DESER_PARITY_EN, word 3'b111 -> out_parity=1.
